// File: rtl/b06_irq_handler_n.sv
//------------------------------------------------------------------------------
// Module  : b06_irq_handler_n
// Brief   : N-channel interrupt handler: arbitrate, count service time, ack.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module b06_irq_handler_n #(
  parameter int NCH         = 4,
  parameter int WAIT_CYCLES = 3,
  parameter int RR_MODE     = 0,
  localparam int CW         = $clog2(NCH)
) (
  input  logic            clock,
  input  logic            nRESET_G,
  input  logic [NCH-1:0]  eql,
  input  logic            cont_eql,
  output logic [CW-1:0]   cc_mux,
  output logic [CW:0]     uscite,
  output logic            enable_count,
  output logic            ackout,
  output logic            busy,
  output logic            abort
);

  localparam int CNTW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ENIN = 2'd1,
    S_ACK  = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [CNTW-1:0]   r_cnt;
  logic [CNTW-1:0]   w_cnt_nx;
  logic [CW-1:0]     r_rr_ptr;
  logic [CW-1:0]     w_rr_nx;
  logic [CW-1:0]     w_cc_nx;
  logic [CW:0]       w_usc_nx;
  logic              w_en_nx;
  logic              w_ack_nx;
  logic              w_abort_nx;
  logic              w_found;
  logic [CW-1:0]     w_winner;
  logic [CW-1:0]     w_idx;
  logic              w_sel_req;
  logic [CW:0]       w_code;

  // Search starts at the round-robin pointer in RR mode, at channel 0 otherwise
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = (RR_MODE != 0) ? CW'((int'(r_rr_ptr) + k) % NCH) : CW'(k);
      if (!w_found && eql[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_sel_req = eql[cc_mux];
  assign w_code    = (CW+1)'(cc_mux) + (CW+1)'(1);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_rr_nx    = r_rr_ptr;
    w_cc_nx    = cc_mux;
    w_usc_nx   = '0;
    w_en_nx    = 1'b0;
    w_ack_nx   = 1'b0;
    w_abort_nx = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (w_found) begin
          w_state_nx = S_ENIN;
          w_cc_nx    = w_winner;
          w_cnt_nx   = '0;
          w_en_nx    = 1'b1;
        end
      end
      S_ENIN: begin
        // Loss of the granted request beats both pause and completion
        if (!w_sel_req) begin
          w_state_nx = S_WAIT;
          w_abort_nx = 1'b1;
        end else if (cont_eql) begin
          w_en_nx = 1'b1;
        end else if (r_cnt == CNTW'(WAIT_CYCLES - 1)) begin
          w_state_nx = S_ACK;
          w_ack_nx   = 1'b1;
          w_usc_nx   = w_code;
        end else begin
          w_cnt_nx = r_cnt + CNTW'(1);
          w_en_nx  = 1'b1;
        end
      end
      S_ACK: begin
        if (w_sel_req) begin
          w_ack_nx = 1'b1;
          w_usc_nx = w_code;
        end else begin
          w_state_nx = S_REL;
          w_rr_nx    = CW'((int'(cc_mux) + 1) % NCH);
        end
      end
      S_REL: begin
        w_state_nx = S_WAIT;
      end
      default: begin
        w_state_nx = S_WAIT;
        w_cc_nx    = '0;
        w_cnt_nx   = '0;
        w_rr_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      r_state      <= S_WAIT;
      r_cnt        <= '0;
      r_rr_ptr     <= '0;
      cc_mux       <= '0;
      uscite       <= '0;
      enable_count <= 1'b0;
      ackout       <= 1'b0;
      busy         <= 1'b0;
      abort        <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_rr_ptr     <= w_rr_nx;
      cc_mux       <= w_cc_nx;
      uscite       <= w_usc_nx;
      enable_count <= w_en_nx;
      ackout       <= w_ack_nx;
      busy         <= (w_state_nx != S_WAIT);
      abort        <= w_abort_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_b06_irq_handler_n.sv
//------------------------------------------------------------------------------
// Module  : tb_b06_irq_handler_n
// Brief   : Directed bench for b06_irq_handler_n, fixed-priority and RR copies.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_b06_irq_handler_n;

  logic       clock;
  logic       nRESET_G;
  logic [3:0] eql_fp, eql_rr;
  logic       cont_fp, cont_rr;
  logic [1:0] cc_fp, cc_rr;
  logic [2:0] usc_fp, usc_rr;
  logic       en_fp, en_rr, ack_fp, ack_rr, busy_fp, busy_rr, abort_fp, abort_rr;

  int checks = 0;
  int errors = 0;

  b06_irq_handler_n #(.NCH(4), .WAIT_CYCLES(3), .RR_MODE(0)) dut_fp (
    .clock(clock), .nRESET_G(nRESET_G), .eql(eql_fp), .cont_eql(cont_fp),
    .cc_mux(cc_fp), .uscite(usc_fp), .enable_count(en_fp), .ackout(ack_fp),
    .busy(busy_fp), .abort(abort_fp)
  );

  b06_irq_handler_n #(.NCH(4), .WAIT_CYCLES(3), .RR_MODE(1)) dut_rr (
    .clock(clock), .nRESET_G(nRESET_G), .eql(eql_rr), .cont_eql(cont_rr),
    .cc_mux(cc_rr), .uscite(usc_rr), .enable_count(en_rr), .ackout(ack_rr),
    .busy(busy_rr), .abort(abort_rr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    nRESET_G = 1'b0;
    eql_fp = '0; eql_rr = '0; cont_fp = 1'b0; cont_rr = 1'b0;
    #12;
    checks++;
    if ({cc_fp, usc_fp, en_fp, ack_fp, busy_fp, abort_fp} !== 9'd0) begin
      errors++;
      $display("FAIL reset_fp got %b exp 0", {cc_fp, usc_fp, en_fp, ack_fp, busy_fp, abort_fp});
    end
    checks++;
    if ({cc_rr, usc_rr, en_rr, ack_rr, busy_rr, abort_rr} !== 9'd0) begin
      errors++;
      $display("FAIL reset_rr got %b exp 0", {cc_rr, usc_rr, en_rr, ack_rr, busy_rr, abort_rr});
    end
    @(posedge clock);
    #1 nRESET_G = 1'b1;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({busy_fp, en_fp, ack_fp, abort_fp} !== 4'b0000) begin
        errors++;
        $display("FAIL idle cyc %0d got %b exp 0000", i, {busy_fp, en_fp, ack_fp, abort_fp});
      end
    end
  endtask

  task automatic test_fixed;
    eql_fp = 4'b0110;
    tick();
    checks++;
    if ({cc_fp, busy_fp, en_fp, ack_fp, usc_fp} !== {2'd1, 3'b110, 3'd0}) begin
      errors++;
      $display("FAIL fixed_grant cc=%0d busy=%b en=%b ack=%b usc=%0d exp cc=1 1 1 0 0",
               cc_fp, busy_fp, en_fp, ack_fp, usc_fp);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({en_fp, ack_fp} !== 2'b10) begin
        errors++;
        $display("FAIL fixed_count cyc %0d en/ack got %b exp 10", i, {en_fp, ack_fp});
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({en_fp, ack_fp, usc_fp} !== {2'b01, 3'd2}) begin
        errors++;
        $display("FAIL fixed_ack cyc %0d en=%b ack=%b usc=%0d exp 0 1 2", i, en_fp, ack_fp, usc_fp);
      end
    end
    eql_fp = 4'b0100;
    tick();
    checks++;
    if ({busy_fp, ack_fp, usc_fp} !== {2'b10, 3'd0}) begin
      errors++;
      $display("FAIL fixed_rel busy=%b ack=%b usc=%0d exp 1 0 0", busy_fp, ack_fp, usc_fp);
    end
    tick();
    checks++;
    if ({busy_fp, en_fp} !== 2'b00) begin
      errors++;
      $display("FAIL fixed_wait busy/en got %b exp 00", {busy_fp, en_fp});
    end
    tick();
    checks++;
    if ({cc_fp, en_fp} !== {2'd2, 1'b1}) begin
      errors++;
      $display("FAIL fixed_next cc=%0d en=%b exp cc=2 en=1", cc_fp, en_fp);
    end
    eql_fp = 4'b0000;
    tick();
    checks++;
    if ({abort_fp, busy_fp, en_fp} !== 3'b100) begin
      errors++;
      $display("FAIL fixed_drop abort/busy/en got %b exp 100", {abort_fp, busy_fp, en_fp});
    end
    tick();
  endtask

  task automatic test_pause;
    int n_en;
    int ack_at;
    eql_fp = 4'b0001;
    tick();
    checks++;
    if ({cc_fp, en_fp} !== {2'd0, 1'b1}) begin
      errors++;
      $display("FAIL pause_grant cc=%0d en=%b exp 0 1", cc_fp, en_fp);
    end
    n_en   = 1;
    ack_at = -1;
    for (int i = 1; i <= 10; i++) begin
      cont_fp = (i <= 2);
      tick();
      if (ack_fp) begin
        ack_at = i;
        break;
      end
      if (en_fp) n_en++;
    end
    cont_fp = 1'b0;
    checks++;
    if (ack_at != 5) begin
      errors++;
      $display("FAIL pause_ack_delay got %0d exp 5", ack_at);
    end
    checks++;
    if (n_en != 5) begin
      errors++;
      $display("FAIL pause_en_cycles got %0d exp 5", n_en);
    end
    eql_fp = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_abort;
    eql_fp = 4'b1000;
    tick();
    checks++;
    if ({cc_fp, en_fp} !== {2'd3, 1'b1}) begin
      errors++;
      $display("FAIL abort_grant cc=%0d en=%b exp 3 1", cc_fp, en_fp);
    end
    tick();
    eql_fp  = 4'b0000;
    cont_fp = 1'b1;
    tick();
    checks++;
    if ({abort_fp, busy_fp, en_fp, ack_fp, usc_fp} !== {4'b1000, 3'd0}) begin
      errors++;
      $display("FAIL abort_pulse abort=%b busy=%b en=%b ack=%b usc=%0d exp 1 0 0 0 0",
               abort_fp, busy_fp, en_fp, ack_fp, usc_fp);
    end
    cont_fp = 1'b0;
    tick();
    checks++;
    if ({abort_fp, busy_fp, ack_fp} !== 3'b000) begin
      errors++;
      $display("FAIL abort_after abort/busy/ack got %b exp 000", {abort_fp, busy_fp, ack_fp});
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] order [5];
    logic [3:0] mask;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    eql_rr = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++;
      if ({cc_rr, en_rr, busy_rr} !== {order[g], 2'b11}) begin
        errors++;
        $display("FAIL rr_grant %0d cc=%0d en=%b busy=%b exp cc=%0d 1 1", g, cc_rr, en_rr, busy_rr, order[g]);
      end
      tick();
      tick();
      tick();
      checks++;
      if ({ack_rr, usc_rr} !== {1'b1, 3'(order[g]) + 3'd1}) begin
        errors++;
        $display("FAIL rr_ack %0d ack=%b usc=%0d exp 1 %0d", g, ack_rr, usc_rr, order[g] + 1);
      end
      mask   = 4'b0001 << order[g];
      eql_rr = 4'b1111 & ~mask;
      tick();
      checks++;
      if ({ack_rr, busy_rr, usc_rr} !== {2'b01, 3'd0}) begin
        errors++;
        $display("FAIL rr_rel %0d ack=%b busy=%b usc=%0d exp 0 1 0", g, ack_rr, busy_rr, usc_rr);
      end
      eql_rr = 4'b1111;
      tick();
      checks++;
      if (busy_rr !== 1'b0) begin
        errors++;
        $display("FAIL rr_wait %0d busy got %b exp 0", g, busy_rr);
      end
    end
  endtask

  task automatic test_reset_mid;
    tick();
    checks++;
    if (cc_rr !== 2'd1) begin
      errors++;
      $display("FAIL mid_grant cc got %0d exp 1", cc_rr);
    end
    tick();
    tick();
    tick();
    checks++;
    if ({ack_rr, usc_rr} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL mid_ack ack=%b usc=%0d exp 1 2", ack_rr, usc_rr);
    end
    #2 nRESET_G = 1'b0;
    #1;
    checks++;
    if ({ack_rr, usc_rr, en_rr, busy_rr, cc_rr} !== 8'd0) begin
      errors++;
      $display("FAIL mid_async ack=%b usc=%0d en=%b busy=%b cc=%0d exp all 0",
               ack_rr, usc_rr, en_rr, busy_rr, cc_rr);
    end
    #1 nRESET_G = 1'b1;
    tick();
    checks++;
    if ({cc_rr, en_rr} !== {2'd0, 1'b1}) begin
      errors++;
      $display("FAIL mid_ptr_cleared cc=%0d en=%b exp 0 1", cc_rr, en_rr);
    end
    eql_rr = 4'b0000;
    tick();
    checks++;
    if ({abort_rr, busy_rr} !== 2'b10) begin
      errors++;
      $display("FAIL mid_cleanup abort/busy got %b exp 10", {abort_rr, busy_rr});
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_fixed();
    test_pause();
    test_abort();
    test_round_robin();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
